// File: rtl/result_collector.sv
// result_collector: absorbs two result streams into per-channel FIFOs and
// merges them onto one valid/ready stream tagged with the source channel.
// Round-robin arbitration; the chosen source is held while the sink stalls.
module result_collector #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid_1,
   input  logic [DATA_WIDTH-1:0] in_data_1,
   input  logic                  in_flush_1,
   output logic                  out_stall_1,
   input  logic                  in_valid_2,
   input  logic [DATA_WIDTH-1:0] in_data_2,
   input  logic                  in_flush_2,
   output logic                  out_stall_2,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_src,
   output logic [CNT_WIDTH-1:0]  beats_1,
   output logic [CNT_WIDTH-1:0]  beats_2
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // index 0 is channel 1, index 1 is channel 2
   logic [1:0]            vld, flush, stall, acc, cand, deq;
   logic [DATA_WIDTH-1:0] din [2];
   logic [DATA_WIDTH-1:0] mem [2][DEPTH];
   logic [AW-1:0]         wr_ptr [2];
   logic [AW-1:0]         rd_ptr [2];
   logic [CW-1:0]         count [2];
   logic [CNT_WIDTH-1:0]  beats [2];
   logic                  rr, lock_valid, lock_src;
   logic                  sel, xfer, any_cand;

   assign vld    = {in_valid_2, in_valid_1};
   assign flush  = {in_flush_2, in_flush_1};
   assign din[0] = in_data_1;
   assign din[1] = in_data_2;

   // Per-channel stall/accept; a flushing channel offers nothing to the arbiter
   always_comb begin
      stall = '0;
      acc   = '0;
      cand  = '0;
      for (int k = 0; k < 2; k++) begin
         stall[k] = (count[k] == FULL);
         acc[k]   = vld[k] & ~stall[k] & ~flush[k];
         cand[k]  = (count[k] != '0) & ~flush[k];
      end
   end

   // Source selection: honour the lock unless its channel is being flushed
   always_comb begin
      sel = 1'b0;
      if (lock_valid && !flush[lock_src])
         sel = lock_src;
      else if (cand[0] && cand[1])
         sel = rr;
      else
         sel = cand[1] & ~cand[0];
      any_cand = |cand;
      xfer     = any_cand & m_ready;
      deq      = {xfer & sel, xfer & ~sel};
      m_data   = any_cand ? mem[sel][rd_ptr[sel]] : '0;
   end

   assign m_valid     = any_cand;
   assign m_src       = sel;
   assign out_stall_1 = stall[0];
   assign out_stall_2 = stall[1];
   assign beats_1     = beats[0];
   assign beats_2     = beats[1];

   // FIFO storage write; contents need no reset since pointers gate reads
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (acc[k])
            mem[k][wr_ptr[k]] <= din[k];
      end
   end

   // FIFO pointers, occupancy and accepted-beat counters
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            wr_ptr[k] <= '0;
            rd_ptr[k] <= '0;
            count[k]  <= '0;
            beats[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (flush[k]) begin
               wr_ptr[k] <= '0;
               rd_ptr[k] <= '0;
               count[k]  <= '0;
            end else begin
               if (acc[k])
                  wr_ptr[k] <= wr_ptr[k] + 1'b1;
               if (deq[k])
                  rd_ptr[k] <= rd_ptr[k] + 1'b1;
               case ({acc[k], deq[k]})
                  2'b10:   count[k] <= count[k] + 1'b1;
                  2'b01:   count[k] <= count[k] - 1'b1;
                  default: count[k] <= count[k];
               endcase
            end
            if (acc[k])
               beats[k] <= beats[k] + 1'b1;
         end
      end
   end

   // Round-robin pointer and output lock while the sink is stalling
   always_ff @(posedge clk) begin
      if (reset) begin
         rr         <= 1'b0;
         lock_valid <= 1'b0;
         lock_src   <= 1'b0;
      end else begin
         if (xfer)
            rr <= ~sel;
         lock_valid <= any_cand & ~m_ready;
         lock_src   <= sel;
      end
   end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a narrow beat counter so wrap is reachable.
module tb_result_collector;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid_1, in_flush_1, in_valid_2, in_flush_2, m_ready;
   logic [31:0] in_data_1, in_data_2;
   logic        out_stall_1, out_stall_2, m_valid, m_src;
   logic [31:0] m_data;
   logic [3:0]  beats_1, beats_2;

   int errors = 0;
   int checks = 0;

   result_collector #(.DATA_WIDTH(32), .DEPTH(4), .CNT_WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid_1(in_valid_1), .in_data_1(in_data_1), .in_flush_1(in_flush_1),
      .out_stall_1(out_stall_1),
      .in_valid_2(in_valid_2), .in_data_2(in_data_2), .in_flush_2(in_flush_2),
      .out_stall_2(out_stall_2),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_src(m_src),
      .beats_1(beats_1), .beats_2(beats_2)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid_1 = 0; in_valid_2 = 0; in_flush_1 = 0; in_flush_2 = 0;
      in_data_1 = '0; in_data_2 = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      m_ready = 1'b0;
      do_reset();
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_src", 32'(m_src), 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_stall_1", 32'(out_stall_1), 0);
      chk("rst_stall_2", 32'(out_stall_2), 0);
      chk("rst_beats_1", 32'(beats_1), 0);

      // single beat
      m_ready = 1; in_valid_1 = 1; in_data_1 = 32'hA5A5_0001;
      step();
      in_valid_1 = 0;
      chk("sb_valid", 32'(m_valid), 1);
      chk("sb_src", 32'(m_src), 0);
      chk("sb_data", m_data, 32'hA5A5_0001);
      chk("sb_beats", 32'(beats_1), 1);
      step();
      chk("sb_empty", 32'(m_valid), 0);

      // fill and stall
      do_reset();
      m_ready = 0;
      for (int i = 0; i < 4; i++) begin
         chk("fill_nostall", 32'(out_stall_1), 0);
         in_valid_1 = 1; in_data_1 = 32'h10 + 32'(i);
         step();
      end
      in_data_1 = 32'h14;
      chk("fill_stall", 32'(out_stall_1), 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fill_hold_beats", 32'(beats_1), 4);
         chk("fill_hold_stall", 32'(out_stall_1), 1);
      end
      chk("fill_head", m_data, 32'h10);
      m_ready = 1;
      step();
      chk("drain_unstall", 32'(out_stall_1), 0);
      chk("drain_d11", m_data, 32'h11);
      chk("drain_beats4", 32'(beats_1), 4);
      step();
      in_valid_1 = 0;
      chk("drain_beats5", 32'(beats_1), 5);
      chk("drain_d12", m_data, 32'h12);
      step();
      chk("drain_d13", m_data, 32'h13);
      step();
      chk("drain_d14", m_data, 32'h14);
      step();
      chk("drain_empty", 32'(m_valid), 0);
      chk("drain_beats_final", 32'(beats_1), 5);

      // round robin
      do_reset();
      m_ready = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid_1 = 1; in_data_1 = 32'h1 + 32'(i);
         in_valid_2 = 1; in_data_2 = 32'hA + 32'(i);
         step();
      end
      in_valid_1 = 0; in_valid_2 = 0;
      m_ready = 1;
      #1;
      for (int i = 0; i < 6; i++) begin
         chk("rr_src", 32'(m_src), 32'(i % 2));
         chk("rr_data", m_data, (i % 2 == 0) ? 32'h1 + 32'(i / 2) : 32'hA + 32'(i / 2));
         step();
      end
      chk("rr_empty", 32'(m_valid), 0);

      // stability under stall
      do_reset();
      m_ready = 0;
      in_valid_2 = 1; in_data_2 = 32'hDEAD_BEEF;
      step();
      in_valid_2 = 0;
      chk("stab_src_first", 32'(m_src), 1);
      step();
      in_valid_1 = 1; in_data_1 = 32'h55;
      step();
      in_valid_1 = 0;
      chk("stab_src_held", 32'(m_src), 1);
      chk("stab_data_held", m_data, 32'hDEAD_BEEF);
      step();
      chk("stab_src_held2", 32'(m_src), 1);
      m_ready = 1;
      step();
      chk("stab_next_src", 32'(m_src), 0);
      chk("stab_next_data", m_data, 32'h55);
      step();
      chk("stab_empty", 32'(m_valid), 0);

      // flush
      do_reset();
      m_ready = 0;
      in_valid_2 = 1; in_data_2 = 32'h41;
      for (int i = 0; i < 3; i++) begin
         in_valid_1 = 1; in_data_1 = 32'h31 + 32'(i);
         step();
         in_valid_2 = 0;
      end
      chk("fl_pre_src", 32'(m_src), 0);
      in_flush_1 = 1; in_valid_1 = 1; in_data_1 = 32'h77;
      #1;
      chk("fl_same_cycle_src", 32'(m_src), 1);
      step();
      in_flush_1 = 0; in_valid_1 = 0;
      chk("fl_valid", 32'(m_valid), 1);
      chk("fl_src", 32'(m_src), 1);
      chk("fl_data", m_data, 32'h41);
      chk("fl_beats", 32'(beats_1), 3);
      m_ready = 1;
      step();
      chk("fl_ch1_empty", 32'(m_valid), 0);
      chk("fl_beats_after", 32'(beats_1), 3);

      // counter wrap then reset mid-drain
      do_reset();
      m_ready = 1;
      for (int i = 0; i < 17; i++) begin
         in_valid_2 = 1; in_data_2 = 32'(i);
         step();
      end
      in_valid_2 = 0;
      chk("wrap_beats_2", 32'(beats_2), 1);
      step();
      m_ready = 0;
      in_valid_1 = 1; in_data_1 = 32'h61; in_valid_2 = 1; in_data_2 = 32'h62;
      step();
      step();
      chk("pre_rst_valid", 32'(m_valid), 1);
      m_ready = 1; reset = 1;
      step();
      reset = 0; in_valid_1 = 0; in_valid_2 = 0;
      chk("mid_rst_valid", 32'(m_valid), 0);
      chk("mid_rst_stall_1", 32'(out_stall_1), 0);
      chk("mid_rst_stall_2", 32'(out_stall_2), 0);
      chk("mid_rst_beats_1", 32'(beats_1), 0);
      chk("mid_rst_beats_2", 32'(beats_2), 0);
      chk("mid_rst_data", m_data, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Downstream consumer for the two result streams of the shared-resource stage: out_valid_k / out_data_k / out_flush_k in, out_stall_k back.
- Per-channel FIFO absorbs results; stall is driven back to the producer when a FIFO is full.
- Both FIFOs merge onto one valid/ready output stream, tagged with source channel, under round-robin arbitration.
- Per-channel accepted-beat counters for debug and statistics.

Parameters:
DATA_WIDTH, 32, width of result data
DEPTH, 4, entries per channel FIFO; power of two, >= 2
CNT_WIDTH, 16, width of beat counters

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid_1  input  1  channel 1 result valid
in_data_1  input  DATA_WIDTH  channel 1 result data
in_flush_1  input  1  channel 1 flush indication
out_stall_1  output  1  backpressure to channel 1 producer
in_valid_2  input  1  channel 2 result valid
in_data_2  input  DATA_WIDTH  channel 2 result data
in_flush_2  input  1  channel 2 flush indication
out_stall_2  output  1  backpressure to channel 2 producer
m_valid  output  1  merged output valid
m_ready  input  1  merged output ready
m_data  output  DATA_WIDTH  merged output data
m_src  output  1  source of m_data: 0 = channel 1, 1 = channel 2
beats_1  output  CNT_WIDTH  accepted beats, channel 1
beats_2  output  CNT_WIDTH  accepted beats, channel 2

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state: both FIFOs empty, counts 0, rr pointer favours channel 1, select lock clear, beats_1 = beats_2 = 0.
- Outputs after reset: m_valid = 0, out_stall_1 = out_stall_2 = 0, m_src = 0, m_data = 0.
- Reset overrides all other activity in the same cycle, including a transfer in flight.
- Input stall: out_stall_k = (count_k == DEPTH). Combinational from registered count only; no dependence on m_ready. A full FIFO stalls even if it dequeues the same cycle.
- Input accept: acc_k = in_valid_k & !out_stall_k & !in_flush_k.
  - Accepted data is written at the tail. Accept-to-m_valid latency is 1 cycle when the FIFO was empty (no bypass).
  - A producer that sees stall holds valid and data; the sink must not capture a beat twice (acceptance only when not stalled).
- Flush:
  - in_flush_k high clears FIFO k at the clock edge: pointers and count return to 0.
  - The beat presented that cycle is discarded and not counted.
  - Channel k is treated as empty for arbitration in that same cycle, so no transfer from k occurs.
  - Flush of one channel does not disturb the other.
- Arbitration:
  - One candidate: it is selected.
  - Both non-empty: the channel favoured by the rr pointer wins.
  - After a transfer (m_valid & m_ready) from channel k, the pointer favours the other channel. The pointer is unchanged when there is no transfer.
- Output stability:
  - When m_valid & !m_ready, the selected channel is latched in the lock register. m_src and m_data stay fixed until the transfer completes.
  - Sole exception: in_flush of the locked channel. The lock clears and re-arbitration happens that cycle; m_valid may drop or switch source.
- Output mapping: m_valid = either candidate non-empty; m_data = head of selected FIFO. m_data is don't-care when m_valid = 0, but is driven 0 after reset.
- Simultaneous enqueue and dequeue on the same FIFO: count unchanged, both pointers advance.
- Pointer and counter widths:
  - FIFO pointers are log2(DEPTH) bits and wrap naturally.
  - count_k is log2(DEPTH)+1 bits.
  - beats_k increments on acc_k and wraps modulo 2^CNT_WIDTH. Cleared only by reset, not by flush.
- Error handling: no error outputs. Overflow cannot occur, since acceptance is blocked when full.

Test Plan:
- Single beat, DEPTH=4: reset; in_valid_1=1, in_data_1=0xA5A5_0001 for 1 cycle with m_ready=1. Expect m_valid=1, m_src=0, m_data=0xA5A5_0001 the next cycle; beats_1=1; m_valid=0 the cycle after.
- Fill and stall: m_ready=0; push 0x10..0x13 on channel 1. Expect out_stall_1=1 after the 4th accept; a 5th offer (0x14) held 3 cycles is not accepted and beats_1 stays 4. Raise m_ready: drain order 0x10, 0x11, 0x12, 0x13; out_stall_1 drops the cycle after the first dequeue; 0x14 is then accepted exactly once.
- Round robin: preload ch1 {1,2,3} and ch2 {A,B,C}, then m_ready=1. Expect output sequence 1,A,2,B,3,C with m_src 0,1,0,1,0,1.
- Stability: ch2 holds X, ch1 empty, m_ready=0, so ch2/X is locked. Push a beat on ch1 (pointer favours ch1). Expect m_src=1, m_data=X unchanged until m_ready=1; ch1's beat follows.
- Flush: ch1 holds 3 entries, ch2 holds 1, m_ready=0. Pulse in_flush_1 with in_valid_1=1, data 0x77. Next cycle: ch1 count 0, beats_1 unchanged, 0x77 absent, m_valid=1 with m_src=1; ch2 entry intact.
- Counter wrap and reset: CNT_WIDTH=4; accept 17 beats on ch2 and expect beats_2=1. Assert reset mid-drain with FIFOs non-empty; next cycle expect m_valid=0, stalls 0, beats 0.
